// File: rtl/fifo_stream_reader_if.sv
// FIFO read side plus valid/ready output stream of fifo_stream_reader.
// The master modport belongs to the reader. The slave modport belongs to its environment.
interface fifo_stream_reader_if #(
  parameter int unsigned WIDTH = 16
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read_update;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read_update, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read_update, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous-read FIFO, absorbs its read latency, and presents words as a
// valid/ready stream. Pops depend only on registered state, so out_ready never reaches the FIFO.
module fifo_stream_reader #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  fifo_stream_reader_if.master   bus,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int unsigned BUF_DEPTH = READ_LATENCY + 2;
  localparam int unsigned OW        = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW        = $clog2(BUF_DEPTH);

  logic [WIDTH-1:0]        mem [BUF_DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [OW-1:0]           occ;
  logic [OW-1:0]           inflight;
  logic [READ_LATENCY-1:0] tags;
  logic                    pop;
  logic                    capture;
  logic                    xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OW'(tags[i]);
    end
  end

  // Reserving a slot for every in-flight word is what makes buffer overflow impossible.
  assign pop = reset && !bus.fifo_empty && !flush &&
               (({1'b0, occ} + {1'b0, inflight}) < (OW + 1)'(BUF_DEPTH));
  assign capture = tags[READ_LATENCY-1];
  assign xfer    = bus.out_valid && bus.out_ready;

  assign bus.fifo_read_update = pop;
  assign bus.out_valid        = (occ != '0);
  assign bus.out_data         = bus.out_valid ? mem[head] : '0;
  assign busy                 = (occ != '0) || (inflight != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ        <= '0;
      head       <= '0;
      tail       <= '0;
      tags       <= '0;
      word_count <= '0;
    end else begin
      if (xfer) word_count <= word_count + COUNT_WIDTH'(1);
      if (flush) begin
        occ  <= '0;
        head <= '0;
        tail <= '0;
        tags <= '0;
      end else begin
        tags <= (tags << 1) | READ_LATENCY'(pop);
        if (capture) tail <= wrap_inc(tail);
        if (xfer)    head <= wrap_inc(head);
        occ <= occ + OW'(capture) - OW'(xfer);
      end
    end
  end

  // Storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (capture && !flush) mem[tail] <= bus.fifo_data;
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: emulated latency FIFO, word-order scoreboard,
// table-driven streaming vectors, hand-written corner sequences and a random soak.
module tb_fifo_stream_reader;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned RL    = 1;
  localparam int unsigned DEPTH = RL + 2;
  localparam int unsigned CW    = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          busy;
  logic [CW-1:0] word_count;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_stream_reader #(
    .WIDTH(WIDTH), .READ_LATENCY(RL), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic             pop;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic [CW-1:0]    wc;
  } vec_t;

  int unsigned      total = 0;
  int unsigned      bad   = 0;
  int unsigned      wc_model = 0;
  int unsigned      pops = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] delivered[$];
  logic [WIDTH-1:0] fd [RL];
  logic             force_empty = 1'b0;
  logic [WIDTH-1:0] seq = 16'h1000;
  vec_t             vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic settle();
    bus.fifo_empty = force_empty || (fifo_q.size() == 0);
    bus.fifo_data  = fd[RL-1];
    #1;
  endtask

  // One clock: sample before the edge, then update the FIFO emulation and scoreboard.
  task automatic tick();
    logic             pre_rst, do_xfer, do_pop, do_flush, was_empty, stall;
    logic [WIDTH-1:0] xdata, w;
    settle();
    pre_rst   = reset;
    do_xfer   = bus.out_valid && bus.out_ready;
    xdata     = bus.out_data;
    do_pop    = bus.fifo_read_update;
    do_flush  = flush;
    was_empty = bus.fifo_empty;
    stall     = bus.out_valid && !bus.out_ready && !flush;
    @(posedge clk);
    @(negedge clk);
    w = WIDTH'($urandom);
    if (pre_rst && reset) begin
      if (do_pop)   check("pop_gated_by_empty", 32'(was_empty), 32'd0);
      if (do_flush) check("no_pop_on_flush", 32'(do_pop), 32'd0);
      if (do_xfer) begin
        wc_model++;
        delivered.push_back(xdata);
        check("xfer_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("xfer_data", 32'(xdata), 32'(exp_q.pop_front()));
      end
      if (do_flush) exp_q.delete();
      if (do_pop && fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
      end
      check("held_bound", 32'(exp_q.size() <= int'(DEPTH)), 32'd1);
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("word_count", 32'(word_count), 32'(wc_model % (1 << CW)));
      if (stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(xdata));
      end
    end
    for (int i = int'(RL) - 1; i > 0; i--) fd[i] = fd[i-1];
    fd[0] = w;
  endtask

  task automatic drain(input int unsigned n, input string name);
    int unsigned guard = 0;
    while ((delivered.size() < n || busy || fifo_q.size() != 0) && guard < 300) begin
      tick();
      guard++;
    end
    check(name, 32'(delivered.size()), n);
  endtask

  task automatic load(input logic [WIDTH-1:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) fifo_q.push_back(first + WIDTH'(i));
  endtask

  initial begin
    // rdy, pop, valid, data, busy, wc: cycle 0 is the first cycle after reset release
    vt[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 4'd0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 4'd1};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 4'd2};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 4'd3};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 4'd4};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 4'd5};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 4'd6};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 4'd7};
    vt[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd8};
    for (int i = 0; i < int'(RL); i++) fd[i] = '0;
    bus.out_ready = 1'b1;
    load(16'h0001, 8);

    // Reset state with a non-empty FIFO.
    settle();
    check("rst_pop", 32'(bus.fifo_read_update), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;

    // Streaming at full rate.
    for (int c = 0; c < 11; c++) begin
      bus.out_ready = vt[c].rdy;
      settle();
      check("vec_pop", 32'(bus.fifo_read_update), 32'(vt[c].pop));
      check("vec_valid", 32'(bus.out_valid), 32'(vt[c].valid));
      check("vec_data", 32'(bus.out_data), 32'(vt[c].data));
      check("vec_busy", 32'(busy), 32'(vt[c].busy));
      check("vec_wc", 32'(word_count), 32'(vt[c].wc));
      tick();
    end

    // Backpressure: only BUF_DEPTH pops, head word held.
    delivered.delete();
    load(16'h0001, 8);
    bus.out_ready = 1'b0;
    pops = 0;
    repeat (8) begin
      settle();
      if (bus.fifo_read_update) pops++;
      tick();
    end
    settle();
    check("bp_pops", pops, 32'd3);
    check("bp_pop_low", 32'(bus.fifo_read_update), 32'd0);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_data", 32'(bus.out_data), 32'h0001);
    bus.out_ready = 1'b1;
    drain(8, "bp_count");
    for (int i = 0; i < 8 && i < delivered.size(); i++)
      check("bp_order", 32'(delivered[i]), 32'(i + 1));

    // Empty FIFO: nothing happens while fifo_data carries garbage.
    repeat (20) begin
      settle();
      check("empty_pop", 32'(bus.fifo_read_update), 32'd0);
      check("empty_valid", 32'(bus.out_valid), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      tick();
    end

    // Flush with two words buffered and one in flight.
    load(16'h0011, 9);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    tick();
    settle();
    check("pre_flush_data", 32'(bus.out_data), 32'h0012);
    check("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    settle();
    check("flush_pop", 32'(bus.fifo_read_update), 32'd0);
    tick();
    flush = 1'b0;
    delivered.delete();
    settle();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_keeps_count", 32'(word_count), 32'd1);
    bus.out_ready = 1'b1;
    drain(5, "flush_count");
    for (int i = 0; i < 5 && i < delivered.size(); i++)
      check("flush_order", 32'(delivered[i]), 32'(16'h0015 + i));
    check("flush_final_wc", 32'(word_count), 32'd6);

    // Asynchronous reset between edges.
    load(16'h0021, 8);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.out_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wc", 32'(word_count), 32'd0);
    check("arst_pop", 32'(bus.fifo_read_update), 32'd0);
    exp_q.delete();
    delivered.delete();
    wc_model = 0;
    tick();
    reset = 1'b1;
    settle();
    check("release_pop", 32'(bus.fifo_read_update), 32'd1);
    tick();
    check("release_busy", 32'(busy), 32'd1);
    bus.out_ready = 1'b1;
    drain(5, "arst_count");
    for (int i = 0; i < 5 && i < delivered.size(); i++)
      check("arst_order", 32'(delivered[i]), 32'(16'h0024 + i));

    // Counter wrap from reset.
    reset = 1'b0;
    exp_q.delete();
    delivered.delete();
    wc_model = 0;
    tick();
    reset = 1'b1;
    load(16'h0031, 17);
    drain(17, "wrap_count");
    check("wrap_wc", 32'(word_count), 32'd1);

    // Random soak against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 3) != 0) begin
        fifo_q.push_back(seq);
        seq++;
      end
      force_empty   = ($urandom_range(0, 4) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    force_empty = 1'b0;
    bus.out_ready = 1'b1;
    for (int g = 0; g < 100 && (fifo_q.size() != 0 || busy); g++) tick();
    check("soak_drained", 32'(exp_q.size() + fifo_q.size()), 32'd0);
    check("soak_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
